// File: rtl/binary_frame_pingpong_ctrl.sv
// binary_frame_pingpong_ctrl
// Double-buffered 1-bit frame store. A writer streams one binary pixel per
// transfer into the back bank in raster order while the display reads the
// front bank. The banks are exchanged only on a vsync edge after a complete
// frame is held, so the display never shows a torn or partial frame.
//
// Ports:
//   pixel_clk   single rising-edge clock
//   sys_rst_n   asynchronous active-low reset
//   wr_valid    writer presents a pixel
//   wr_sof      marks the pixel as (0,0) of a new frame
//   wr_pixel    binary pixel value
//   wr_ready    a pixel is accepted this cycle (low while a full frame waits)
//   video_vs    display vertical sync
//   rd_x, rd_y  display read coordinates
//   rd_data     registered display pixel, 0 outside the image
//   swap_pulse  one-cycle strobe on bank exchange
//   disp_valid  front bank holds a complete frame (sticky)
//   frame_cnt   number of completed swaps, wraps at 255
//
// Write FSM states:
//   state  | meaning
//   S_IDLE | waiting for a wr_sof pixel; other pixels are dropped
//   S_FILL | filling the back bank in raster order
//   S_DONE | back bank complete; backpressure until the next vsync edge
module binary_frame_pingpong_ctrl #(
   parameter int   IMG_W     = 28,
   parameter int   IMG_H     = 28,
   parameter logic VS_ACTIVE = 1'b1
) (
   input  logic       pixel_clk,
   input  logic       sys_rst_n,
   input  logic       wr_valid,
   input  logic       wr_sof,
   input  logic       wr_pixel,
   output logic       wr_ready,
   input  logic       video_vs,
   input  logic [4:0] rd_x,
   input  logic [4:0] rd_y,
   output logic       rd_data,
   output logic       swap_pulse,
   output logic       disp_valid,
   output logic [7:0] frame_cnt
);

   localparam int         NPIX   = IMG_W * IMG_H;
   localparam int         AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [4:0] X_LAST = 5'(IMG_W - 1);
   localparam logic [4:0] Y_LAST = 5'(IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} wr_state_t;

   wr_state_t       state;
   logic [4:0]      wr_x;
   logic [4:0]      wr_y;
   logic            disp_bank;
   logic            vs_q;
   logic [NPIX-1:0] bank_mem [2];

   logic            xfer;
   logic            vs_edge;
   logic            wr_bank;
   logic            rd_in_range;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;

   assign xfer        = wr_valid & wr_ready;
   assign vs_edge     = (video_vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);
   assign wr_bank     = ~disp_bank;
   assign wr_addr     = AW'(32'(wr_y) * IMG_W + 32'(wr_x));
   assign rd_addr     = AW'(32'(rd_y) * IMG_W + 32'(rd_x));
   assign rd_in_range = (32'(rd_x) < IMG_W) && (32'(rd_y) < IMG_H);

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         wr_x        <= '0;
         wr_y        <= '0;
         disp_bank   <= 1'b0;
         bank_mem[0] <= '0;
         bank_mem[1] <= '0;
         wr_ready    <= 1'b1;
         swap_pulse  <= 1'b0;
         disp_valid  <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         swap_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (xfer && wr_sof) begin
                  bank_mem[wr_bank][0] <= wr_pixel;
                  wr_x  <= 5'd1;
                  wr_y  <= '0;
                  state <= S_FILL;
               end
            end
            S_FILL: begin
               if (xfer && wr_sof) begin
                  // Restart: the abandoned partial frame is simply overwritten.
                  bank_mem[wr_bank][0] <= wr_pixel;
                  wr_x <= 5'd1;
                  wr_y <= '0;
               end else if (xfer) begin
                  bank_mem[wr_bank][wr_addr] <= wr_pixel;
                  if (wr_x == X_LAST) begin
                     wr_x <= '0;
                     if (wr_y == Y_LAST) begin
                        wr_y     <= '0;
                        state    <= S_DONE;
                        wr_ready <= 1'b0;
                     end else begin
                        wr_y <= wr_y + 5'd1;
                     end
                  end else begin
                     wr_x <= wr_x + 5'd1;
                  end
               end
            end
            S_DONE: begin
               // A vsync edge coinciding with the last pixel lands in S_FILL
               // and is ignored, so the swap waits for the following edge.
               if (vs_edge) begin
                  disp_bank  <= ~disp_bank;
                  swap_pulse <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  disp_valid <= 1'b1;
                  wr_ready   <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

   // Read uses disp_bank as it stands before the edge, so a read sampled in
   // the swap cycle still returns the old frame.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_data <= 1'b0;
         vs_q    <= ~VS_ACTIVE;
      end else begin
         vs_q <= video_vs;
         if (rd_in_range) begin
            rd_data <= bank_mem[disp_bank][rd_addr];
         end else begin
            rd_data <= 1'b0;
         end
      end
   end

endmodule

// File: doc/binary_frame_pingpong_ctrl.md
BINARY_FRAME_PINGPONG_CTRL -- requirements
Module: binary_frame_pingpong_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in lines.
REQ-003 SHALL have parameter VS_ACTIVE, default 1'b1, video_vs level that marks the vertical sync interval.
REQ-004 SHALL have port pixel_clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  1  writer presents one binary pixel.
REQ-007 SHALL have port wr_sof  input  1  qualifies wr_valid; this pixel is pixel (0,0) of a new frame.
REQ-008 SHALL have port wr_pixel  input  1  binary pixel value.
REQ-009 SHALL have port wr_ready  output  1  the controller accepts a pixel this cycle.
REQ-010 SHALL have port video_vs  input  1  display vertical sync from the video timing generator.
REQ-011 SHALL have port rd_x  input  5  display read column.
REQ-012 SHALL have port rd_y  input  5  display read row.
REQ-013 SHALL have port rd_data  output  1  pixel of the display bank at (rd_x, rd_y).
REQ-014 SHALL have port swap_pulse  output  1  one-cycle strobe when the banks swap.
REQ-015 SHALL have port disp_valid  output  1  the display bank holds a complete frame.
REQ-016 SHALL have port frame_cnt  output  8  count of completed swaps.

Function
REQ-017 SHALL hold two banks of IMG_W*IMG_H bits each; disp_bank (1 bit) selects the bank that is read, and the other bank is written.
REQ-018 SHALL implement write FSM states IDLE, FILL and DONE.
REQ-019 SHALL define a transfer as wr_valid & wr_ready in the same cycle.
REQ-020 SHALL drive wr_ready = 1 in IDLE and FILL, and wr_ready = 0 in DONE (backpressure).
REQ-021 In IDLE, a transfer with wr_sof=1 SHALL write pixel (0,0), set wr_x=1, wr_y=0 and go to FILL; a transfer with wr_sof=0 SHALL be discarded.
REQ-022 In FILL, a transfer with wr_sof=0 SHALL write (wr_x, wr_y) and advance raster order: wr_x wraps at IMG_W-1 to 0, and wr_y then increments.
REQ-023 In FILL, a transfer with wr_sof=1 SHALL restart the frame at (0,0); the partial frame is abandoned and its content is don't-care.
REQ-024 Acceptance of pixel (IMG_W-1, IMG_H-1) SHALL move the FSM to DONE on the next edge.
REQ-025 SHALL detect a vsync edge as video_vs==VS_ACTIVE in the current cycle and !=VS_ACTIVE in the previous cycle, using one registered copy of video_vs.
REQ-026 A vsync edge while the FSM is in DONE SHALL toggle disp_bank, assert swap_pulse for exactly 1 cycle, increment frame_cnt (255 wraps to 0), set disp_valid=1 (sticky) and return the FSM to IDLE, all on the same edge.
REQ-027 A vsync edge while the FSM is in IDLE or FILL SHALL have no effect, so the display keeps the old bank.
REQ-028 A vsync edge coinciding with acceptance of the last pixel SHALL NOT swap; the swap SHALL occur on the next vsync edge.
REQ-029 rd_data SHALL be registered with 1-cycle latency from rd_x/rd_y and read from the bank selected by disp_bank at sampling time.
REQ-030 rd_data SHALL be 0 when rd_x >= IMG_W or rd_y >= IMG_H.
REQ-031 A read sampled in the swap cycle SHALL return the old bank; a read sampled on the following cycle SHALL return the new bank.
REQ-032 Writes SHALL never target the display bank.

Reset
REQ-033 While sys_rst_n=0, the block SHALL hold: FSM=IDLE, wr_x=wr_y=0, disp_bank=0, both banks all-zero, wr_ready=1, rd_data=0, swap_pulse=0, disp_valid=0, frame_cnt=0, registered video_vs=!VS_ACTIVE.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require wr_sof before accepting pixels.

Verification
REQ-035 Reset, then write 784 pixels with the checkerboard value (x^y)&1 starting with wr_sof, then apply one vsync edge -> swap_pulse=1 for 1 cycle, frame_cnt=1, disp_valid=1; reading (1,0) returns 1 and (1,1) returns 0 one cycle later.
REQ-036 Complete a frame, then hold wr_valid=1 with no vsync for 50 cycles -> wr_ready=0 throughout and the display bank is unchanged; after a vsync edge, wr_ready=1 on the next cycle.
REQ-037 Write 400 pixels, then assert wr_sof again and write 784 all-ones pixels, then apply vsync -> the display bank reads all 1s at every (x,y) with x<28 and y<28.
REQ-038 Apply a vsync edge in the same cycle the 784th pixel is accepted -> no swap_pulse; the next vsync edge produces swap_pulse and frame_cnt increments by 1.
REQ-039 Read at rd_x=28,y=5 and at rd_x=3,y=31 -> rd_data=0; run 256 swaps -> frame_cnt wraps to 0.
REQ-040 Assert reset after 300 written pixels -> all outputs return to their reset values; wr_sof=0 pixels after release are ignored (FSM stays IDLE).
